// File: rtl/cpu_if_arbiter_if.sv
// cpu_if -- simple CPU-style register bus between a requester and a device.
//   req/req_is_wr/addr/wr_data/wr_biten : request, driven by the requester
//   req_stall_wr/req_stall_rd           : device not ready for a write/read
//   rd_ack/rd_err/rd_data               : read completion
//   wr_ack/wr_err                       : write completion
// Modports:
//   dev : device side (receives requests, returns stalls/acks)
//   cpu : requester side (issues requests, receives stalls/acks)
interface cpu_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  req;
  logic                  req_is_wr;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] wr_biten;
  logic                  req_stall_wr;
  logic                  req_stall_rd;
  logic                  rd_ack;
  logic                  rd_err;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  wr_ack;
  logic                  wr_err;

  modport dev (
    input  req, req_is_wr, addr, wr_data, wr_biten,
    output req_stall_wr, req_stall_rd, rd_ack, rd_err, rd_data, wr_ack, wr_err
  );

  modport cpu (
    output req, req_is_wr, addr, wr_data, wr_biten,
    input  req_stall_wr, req_stall_rd, rd_ack, rd_err, rd_data, wr_ack, wr_err
  );
endinterface

// File: rtl/cpu_if_arbiter.sv
// cpu_if_arbiter -- two-requester round-robin arbiter onto one downstream
// register block, with at most one transaction outstanding.
// Ports:
//   clk   : clock, all state on rising edge
//   reset : synchronous active-high reset
//   m0    : requester 0 (holds priority after reset)
//   m1    : requester 1
//   s     : shared downstream register block
// Build option:
//   CPU_ARB_TIMEOUT_EN : when defined, a WAIT that lasts TIMEOUT_CYCLES
//                        cycles without an ack is completed locally with
//                        err = 1. Undefined: WAIT lasts until an ack.
module cpu_if_arbiter #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  cpu_if.dev   m0,
  cpu_if.dev   m1,
  cpu_if.cpu   s
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("cpu_if_arbiter: TIMEOUT_CYCLES out of range 1..65535");
  end

  typedef enum logic {IDLE, WAIT} state_t;

  state_t state_q, state_d;
  logic   prio_q, prio_d;   // port that wins a tie
  logic   gnt_q, gnt_d;     // port owning the outstanding transaction

  // Requester views gathered into port-indexed arrays
  logic [1:0]                 p_req, p_wr;
  logic [1:0][ADDR_WIDTH-1:0] p_addr;
  logic [1:0][DATA_WIDTH-1:0] p_wdata, p_biten;

  assign p_req   = {m1.req, m0.req};
  assign p_wr    = {m1.req_is_wr, m0.req_is_wr};
  assign p_addr  = {m1.addr, m0.addr};
  assign p_wdata = {m1.wr_data, m0.wr_data};
  assign p_biten = {m1.wr_biten, m0.wr_biten};

  logic win, cur, idle, s_req, s_is_wr, accept, fwd, complete, timeout;

  assign idle     = (state_q == IDLE);
  assign win      = (p_req == 2'b11) ? prio_q : p_req[1];
  assign s_is_wr  = p_wr[win];
  assign s_req    = !reset && idle && (|p_req);
  assign accept   = s_req && !(s_is_wr ? s.req_stall_wr : s.req_stall_rd);
  // Acks are only meaningful while a transaction is live: in WAIT, or in
  // the IDLE cycle the request is accepted (zero-latency completion).
  assign fwd      = accept || (!reset && state_q == WAIT);
  assign cur      = idle ? win : gnt_q;
  assign complete = fwd && (s.rd_ack || s.wr_ack);

  assign s.req       = s_req;
  assign s.req_is_wr = s_is_wr;
  assign s.addr      = p_addr[win];
  assign s.wr_data   = p_wdata[win];
  assign s.wr_biten  = p_biten[win];

`ifdef CPU_ARB_TIMEOUT_EN
  logic [15:0] cnt_q;
  logic        wr_q;   // direction of the outstanding transaction

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      wr_q  <= 1'b0;
    end else begin
      if (idle)                       cnt_q <= '0;
      else if (!complete && !timeout) cnt_q <= cnt_q + 16'd1;
      if (accept) wr_q <= s_is_wr;
    end
  end

  // A real ack in the same cycle takes precedence over the timeout.
  assign timeout = !reset && (state_q == WAIT) && !complete &&
                   (cnt_q == 16'(TIMEOUT_CYCLES));
`else
  assign timeout = 1'b0;
`endif

  logic [1:0]                 stall_wr, stall_rd, rd_ack, rd_err, wr_ack, wr_err;
  logic [1:0][DATA_WIDTH-1:0] rd_data;

  always_comb begin
    stall_wr = '1;
    stall_rd = '1;
    rd_ack   = '0;
    rd_err   = '0;
    wr_ack   = '0;
    wr_err   = '0;
    rd_data  = '0;
    state_d  = state_q;
    prio_d   = prio_q;
    gnt_d    = gnt_q;

    if (s_req) begin
      stall_wr[win] = s.req_stall_wr;
      stall_rd[win] = s.req_stall_rd;
    end

    if (fwd) begin
      rd_ack[cur]  = s.rd_ack;
      rd_err[cur]  = s.rd_err;
      wr_ack[cur]  = s.wr_ack;
      wr_err[cur]  = s.wr_err;
      rd_data[cur] = s.rd_ack ? s.rd_data : '0;
    end

`ifdef CPU_ARB_TIMEOUT_EN
    if (timeout) begin
      if (wr_q) begin
        wr_ack[gnt_q] = 1'b1;
        wr_err[gnt_q] = 1'b1;
      end else begin
        rd_ack[gnt_q] = 1'b1;
        rd_err[gnt_q] = 1'b1;
      end
    end
`endif

    case (state_q)
      IDLE: if (accept) begin
        if (complete) prio_d = ~win;
        else begin
          state_d = WAIT;
          gnt_d   = win;
        end
      end
      WAIT: if (complete || timeout) begin
        state_d = IDLE;
        prio_d  = ~gnt_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      gnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      gnt_q   <= gnt_d;
    end
  end

  assign m0.req_stall_wr = stall_wr[0];
  assign m0.req_stall_rd = stall_rd[0];
  assign m0.rd_ack       = rd_ack[0];
  assign m0.rd_err       = rd_err[0];
  assign m0.rd_data      = rd_data[0];
  assign m0.wr_ack       = wr_ack[0];
  assign m0.wr_err       = wr_err[0];

  assign m1.req_stall_wr = stall_wr[1];
  assign m1.req_stall_rd = stall_rd[1];
  assign m1.rd_ack       = rd_ack[1];
  assign m1.rd_err       = rd_err[1];
  assign m1.rd_data      = rd_data[1];
  assign m1.wr_ack       = wr_ack[1];
  assign m1.wr_err       = wr_err[1];

endmodule

// File: doc/cpu_if_arbiter.md
CPU_IF_ARBITER -- requirements
Module: cpu_if_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, address width of all three ports.
REQ-002 Parameter DATA_WIDTH, default 16, data/biten width of all three ports.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, ack timeout in clk cycles, range 1..65535; used only under CPU_ARB_TIMEOUT_EN.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 m0  cpu_if.dev  --  requester 0 (higher priority after reset).
REQ-007 m1  cpu_if.dev  --  requester 1.
REQ-008 s  cpu_if.cpu  --  shared downstream register block.

Function
REQ-009 The block SHALL implement FSM states IDLE and WAIT and hold at most one outstanding downstream transaction.
REQ-010 In IDLE the winner SHALL be the only requesting port, or the port holding priority if both m0.req and m1.req are high.
REQ-011 In IDLE the winner's req, req_is_wr, addr, wr_data and wr_biten SHALL pass combinationally to s (zero-cycle issue latency); s.req SHALL be 0 if no port requests.
REQ-012 In IDLE the winner SHALL see s.req_stall_wr/s.req_stall_rd; the loser and any idle port SHALL see both stalls = 1.
REQ-013 Issue is accepted when s.req=1 and the stall matching s.req_is_wr is 0; on acceptance the grant SHALL be latched and the FSM SHALL enter WAIT, unless the matching ack is returned in the same cycle (REQ-016).
REQ-014 In WAIT, s.req SHALL be 0 and both ports SHALL see both stalls = 1.
REQ-015 In WAIT, s.rd_ack, s.rd_err, s.rd_data, s.wr_ack, s.wr_err SHALL route to the granted port only; the other port SHALL see ack/err = 0 and rd_data = 0.
REQ-016 Completion is s.rd_ack or s.wr_ack in WAIT, or in the IDLE acceptance cycle; on completion the FSM SHALL be IDLE next cycle and priority SHALL move to the port not just served.
REQ-017 Same-cycle completion in IDLE SHALL route the ack to the current winner and SHALL NOT enter WAIT.
REQ-018 A port requesting while stalled SHALL hold its request stable; the arbiter SHALL NOT drop or reorder it. Back-to-back requests from one port SHALL alternate with the other port when both are pending (strict round-robin).
REQ-019 Ack/err from s while in IDLE with no accepted request SHALL be discarded (not forwarded).
REQ-020 Non-granted ports' ack, err and rd_data outputs SHALL be 0 every cycle.

Reset
REQ-021 While reset=1: FSM = IDLE, priority = m0, timeout counter = 0, s.req = 0, all port stalls = 1, all port acks/errs = 0, all port rd_data = 0.
REQ-022 Reset asserted in WAIT SHALL abandon the outstanding transaction with no ack to either port; a downstream ack arriving after reset deassertion SHALL be discarded per REQ-019.
REQ-023 After reset deassertion the first request SHALL be issuable in the first cycle reset is low.

Configuration
REQ-024 Macro CPU_ARB_TIMEOUT_EN, when defined, SHALL add a 16-bit counter, cleared on WAIT entry, incremented each WAIT cycle without completion.
REQ-025 With CPU_ARB_TIMEOUT_EN, when the counter reaches TIMEOUT_CYCLES the granted port SHALL receive a one-cycle ack (rd_ack or wr_ack per latched direction) with err = 1 and rd_data = 0, FSM to IDLE, priority rotated.
REQ-026 With CPU_ARB_TIMEOUT_EN, a real ack arriving in the same cycle as the timeout SHALL win (normal completion, err from s).
REQ-027 Without CPU_ARB_TIMEOUT_EN, no counter SHALL exist and WAIT SHALL persist until a downstream ack.

Verification
REQ-028 Single read: m0 read addr 0x0010, s acks 2 cycles later with rd_data 0xBEEF -> m0.rd_ack=1, m0.rd_data=0xBEEF for 1 cycle; m1 sees 0.
REQ-029 Contention: m0 and m1 both write in the same cycle after reset -> m0 issues first, m1 stalled; after m0 wr_ack, m1 issues next; a third simultaneous pair issues m0 again.
REQ-030 Same-cycle ack: s returns rd_ack in acceptance cycle for m1 read 0x0004 -> m1.rd_ack same cycle, FSM stays IDLE, next m0 request issued next cycle.
REQ-031 Downstream stall: s.req_stall_wr=1 for 3 cycles on m1 write -> s.req held with identical addr/wr_data/wr_biten for 3 cycles, issue on 4th.
REQ-032 Reset mid-WAIT: reset pulsed 1 cycle in WAIT, then s.rd_ack -> no port ack, next request issued normally.
REQ-033 Timeout (CPU_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): m0 read, s never acks -> m0.rd_ack=1, m0.rd_err=1, rd_data=0 after 8 WAIT cycles; without macro m0 stays stalled.
